// File: rtl/vec_serializer.sv
// ---------------------------------------------------------------------------
// vec_serializer
//
// Purpose:
//   Takes one LENGTH-element vector of WIDTH-bit words and streams its
//   elements out one per cycle under ready/valid flow control. One vector is
//   held at a time; a new vector can be accepted in the same cycle the final
//   element of the current one is taken, so back-to-back vectors flow with
//   no bubble.
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   in_valid   in_vec holds a valid vector
//   in_ready   block accepts in_vec this cycle (combinational)
//   in_vec     unpacked array of LENGTH elements, index 0 first
//   out_valid  out_data holds a valid element (registered)
//   out_ready  downstream accepts out_data this cycle
//   out_data   current element (registered)
//   out_idx    index of the current element within its vector (registered)
//   out_last   high with the final element of a vector (registered)
//
// Configuration macro:
//   VEC_SER_REVERSE_EN  when defined, elements are emitted from index
//                       LENGTH-1 down to 0 and out_last marks index 0.
// ---------------------------------------------------------------------------
module vec_serializer #(
  parameter  int WIDTH  = 1,
  parameter  int LENGTH = 1,
  localparam int IDXW   = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec [LENGTH],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

`ifdef VEC_SER_REVERSE_EN
  localparam logic [IDXW-1:0] FIRST_IDX = IDXW'(LENGTH - 1);
  localparam logic [IDXW-1:0] END_IDX   = '0;
`else
  localparam logic [IDXW-1:0] FIRST_IDX = '0;
  localparam logic [IDXW-1:0] END_IDX   = IDXW'(LENGTH - 1);
`endif

  state_t           state;
  state_t           state_nxt;
  logic             rdy_en;
  logic             accept;
  logic             xfer;
  logic [IDXW-1:0]  step_idx;
  logic [WIDTH-1:0] vreg [LENGTH];

  // in_ready must stay low during reset and only rise after the first clock
  // edge following release, so a one-bit enable is held in reset alongside
  // the FSM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode. A vector may be taken while idle, or
  // while the final element of the held vector leaves this cycle, which is
  // what removes the bubble between back-to-back vectors. in_ready never
  // looks at in_valid.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    xfer      = out_valid & out_ready;
    case (state)
      IDLE: in_ready = rdy_en;
      SEND: in_ready = rdy_en & xfer & out_last;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid & in_ready;
    case (state)
      IDLE: if (accept) state_nxt = SEND;
      SEND: if (xfer && out_last && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Index of the element that follows the current one. Saturating at the
  // final index keeps the vector read in range; that value is never used
  // because the final element is left only by reload or by going idle.
  always_comb begin
    step_idx = out_idx;
    if (out_idx != END_IDX) begin
`ifdef VEC_SER_REVERSE_EN
      step_idx = out_idx - 1'b1;
`else
      step_idx = out_idx + 1'b1;
`endif
    end
  end

  // Vector register and registered output stage. On accept the first
  // element is taken straight from in_vec into the output register, so it
  // appears one cycle after the accept; later elements come from the held
  // copy. Under backpressure nothing here changes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      for (int i = 0; i < LENGTH; i++) begin
        vreg[i] <= '0;
      end
    end else if (accept) begin
      vreg      <= in_vec;
      out_valid <= 1'b1;
      out_data  <= in_vec[FIRST_IDX];
      out_idx   <= FIRST_IDX;
      out_last  <= (FIRST_IDX == END_IDX);
    end else if (xfer) begin
      if (out_last) begin
        out_valid <= 1'b0;
      end else begin
        out_data <= vreg[step_idx];
        out_idx  <= step_idx;
        out_last <= (step_idx == END_IDX);
      end
    end
  end

endmodule

// File: tb/tb_vec_serializer.sv
// ---------------------------------------------------------------------------
// tb_vec_serializer
//
// Self-checking bench for vec_serializer. A WIDTH=8, LENGTH=4 instance is
// exercised with a per-cycle vector table, hand-written sequences for
// back-to-back, reset mid-vector and reset release, and a randomized run
// against a queue-based reference model. A second LENGTH=1 instance checks
// single-element streaming. Expected order follows VEC_SER_REVERSE_EN.
// ---------------------------------------------------------------------------
module tb_vec_serializer;

  localparam int W = 8;
  localparam int L = 4;

  logic         clk;
  logic         rstn;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_vec [L];
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_idx;
  logic         out_last;

  logic         in_valid1;
  logic         in_ready1;
  logic [W-1:0] in_vec1 [1];
  logic         out_valid1;
  logic         out_ready1;
  logic [W-1:0] out_data1;
  logic [0:0]   out_idx1;
  logic         out_last1;

  int checks = 0;
  int errors = 0;

  vec_serializer #(.WIDTH(W), .LENGTH(L)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
  );

  vec_serializer #(.WIDTH(W), .LENGTH(1)) dut1 (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_vec(in_vec1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_idx(out_idx1), .out_last(out_last1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Element index emitted at stream position k of a vector.
  function automatic int ord(input int k, input int len);
`ifdef VEC_SER_REVERSE_EN
    return len - 1 - k;
`else
    return k;
`endif
  endfunction

  // Compare one value and log a failure line if it differs.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive the main instance after the falling edge, then settle before
  // sampling so every check sits half a cycle from the active edge.
  task automatic applyStimulus(input bit iv, input bit ordy,
                               input logic [W-1:0] v [L]);
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    in_vec    = v;
    #1;
  endtask

  // Check the presented element against stream position k of vector v.
  task automatic checkElem(input string name, input logic [W-1:0] v [L],
                           input int k);
    checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({name, "_data"},  32'(out_data),  32'(v[ord(k, L)]));
    checkOutput({name, "_idx"},   32'(out_idx),   32'(ord(k, L)));
    checkOutput({name, "_last"},  32'(out_last),  32'(k == L - 1));
  endtask

  typedef struct {
    bit iv;
    bit ordy;
    bit junk;
    bit exp_valid;
    int exp_k;
    bit exp_rdy;
  } row_t;

  typedef struct {
    logic [W-1:0] data;
    int           idx;
    bit           last;
  } exp_t;

  row_t         tbl [9];
  exp_t         q [$];
  logic [W-1:0] v1 [L];
  logic [W-1:0] v2 [L];
  logic [W-1:0] v3 [L];
  logic [W-1:0] vj [L];
  logic [W-1:0] vr [L];

  initial begin
    v1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    v2 = '{8'h55, 8'h66, 8'h77, 8'h88};
    v3 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    vj = '{8'h5A, 8'hA5, 8'hC3, 8'h3C};

    // Single vector with a three-cycle stall on stream position 1. Row 3
    // raises in_valid with junk data while busy; it must be ignored.
    tbl[0] = '{1, 1, 0, 0, 0, 1};
    tbl[1] = '{0, 1, 0, 1, 0, 0};
    tbl[2] = '{0, 0, 0, 1, 1, 0};
    tbl[3] = '{1, 0, 1, 1, 1, 0};
    tbl[4] = '{0, 0, 0, 1, 1, 0};
    tbl[5] = '{0, 1, 0, 1, 1, 0};
    tbl[6] = '{0, 1, 0, 1, 2, 0};
    tbl[7] = '{0, 1, 0, 1, 3, 1};
    tbl[8] = '{0, 1, 0, 0, 0, 1};

    rstn       = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_vec     = vj;
    in_valid1  = 1'b0;
    out_ready1 = 1'b0;
    in_vec1[0] = '0;

    // Reset state.
    #12;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data",  32'(out_data),  32'd0);
    checkOutput("rst_out_idx",   32'(out_idx),   32'd0);
    checkOutput("rst_out_last",  32'(out_last),  32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checkOutput("rel_in_ready_pre_clk", 32'(in_ready), 32'd0);
    applyStimulus(0, 1, vj);
    checkOutput("idle_in_ready",  32'(in_ready),  32'd1);
    checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
    checkOutput("idle_out_data",  32'(out_data),  32'd0);

    // Table-driven single vector with backpressure.
    for (int r = 0; r < 9; r++) begin
      applyStimulus(tbl[r].iv, tbl[r].ordy, tbl[r].junk ? vj : v1);
      checkOutput($sformatf("tbl%0d_in_ready", r), 32'(in_ready), 32'(tbl[r].exp_rdy));
      if (tbl[r].exp_valid) begin
        checkElem($sformatf("tbl%0d", r), v1, tbl[r].exp_k);
      end else begin
        checkOutput($sformatf("tbl%0d_valid", r), 32'(out_valid), 32'd0);
      end
    end

    // Back-to-back vectors: eight consecutive valid cycles, second accept
    // in the cycle the first vector's final element transfers.
    applyStimulus(1, 1, v1);
    checkOutput("b2b_accept1_rdy", 32'(in_ready), 32'd1);
    for (int c = 1; c <= 8; c++) begin
      applyStimulus(c <= 4, 1, v2);
      checkElem($sformatf("b2b%0d", c), (c <= 4) ? v1 : v2, (c - 1) % 4);
      checkOutput($sformatf("b2b%0d_in_ready", c), 32'(in_ready), 32'(c == 4 || c == 8));
    end
    applyStimulus(0, 1, v2);
    checkOutput("b2b_end_valid", 32'(out_valid), 32'd0);

    // Reset mid-vector after stream position 1 has transferred.
    applyStimulus(1, 1, v1);
    applyStimulus(0, 1, v1);
    applyStimulus(0, 1, v1);
    applyStimulus(0, 1, v1);
    checkElem("mid_pre", v1, 2);
    rstn = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_data",  32'(out_data),  32'd0);
    checkOutput("mid_rst_ready", 32'(in_ready),  32'd0);
    @(negedge clk);
    checkOutput("mid_rst_hold_valid", 32'(out_valid), 32'd0);
    rstn = 1'b1;
    #1;
    checkOutput("mid_rel_ready", 32'(in_ready), 32'd0);
    applyStimulus(0, 1, v3);
    checkOutput("mid_no_output", 32'(out_valid), 32'd0);
    applyStimulus(1, 1, v3);
    checkOutput("mid_accept_rdy", 32'(in_ready), 32'd1);
    for (int k = 0; k < L; k++) begin
      applyStimulus(0, 1, v3);
      checkElem($sformatf("mid_new%0d", k), v3, k);
    end
    applyStimulus(0, 1, v3);
    checkOutput("mid_end_valid", 32'(out_valid), 32'd0);

    // LENGTH=1 streaming: one element per cycle, out_last every cycle.
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      in_valid1  = (c < 5);
      out_ready1 = 1'b1;
      in_vec1[0] = 8'(8'h10 + c);
      #1;
      checkOutput($sformatf("l1_%0d_ready", c), 32'(in_ready1), 32'd1);
      if (c >= 1 && c <= 5) begin
        checkOutput($sformatf("l1_%0d_valid", c), 32'(out_valid1), 32'd1);
        checkOutput($sformatf("l1_%0d_data", c),  32'(out_data1),  32'(8'h10 + c - 1));
        checkOutput($sformatf("l1_%0d_idx", c),   32'(out_idx1),   32'd0);
        checkOutput($sformatf("l1_%0d_last", c),  32'(out_last1),  32'd1);
      end else begin
        checkOutput($sformatf("l1_%0d_valid", c), 32'(out_valid1), 32'd0);
      end
    end
    in_valid1 = 1'b0;

    // Randomized traffic against a queue of expected elements: an accepted
    // vector contributes LENGTH elements in emission order, each transfer
    // removes the head. The block can take a vector when nothing is pending
    // or when only the final element is pending and is being taken.
    for (int c = 0; c < 400; c++) begin
      bit iv;
      bit ordy;
      bit exp_rdy;
      iv   = ($urandom_range(0, 1) == 1);
      ordy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < L; i++) vr[i] = 8'($urandom);
      applyStimulus(iv, ordy, vr);
      exp_rdy = (q.size() == 0) || (q.size() == 1 && ordy);
      checkOutput($sformatf("rnd%0d_in_ready", c), 32'(in_ready), 32'(exp_rdy));
      checkOutput($sformatf("rnd%0d_valid", c), 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        checkOutput($sformatf("rnd%0d_data", c), 32'(out_data), 32'(q[0].data));
        checkOutput($sformatf("rnd%0d_idx", c),  32'(out_idx),  32'(q[0].idx));
        checkOutput($sformatf("rnd%0d_last", c), 32'(out_last), 32'(q[0].last));
        if (ordy) void'(q.pop_front());
      end
      if (iv && exp_rdy) begin
        for (int k = 0; k < L; k++) begin
          exp_t e;
          e.data = vr[ord(k, L)];
          e.idx  = ord(k, L);
          e.last = (k == L - 1);
          q.push_back(e);
        end
      end
    end

    // Drain whatever the random run left pending.
    for (int c = 0; c < 8 && q.size() != 0; c++) begin
      applyStimulus(0, 1, vj);
      checkOutput("drain_valid", 32'(out_valid), 32'd1);
      checkOutput("drain_data",  32'(out_data),  32'(q[0].data));
      void'(q.pop_front());
    end
    applyStimulus(0, 1, vj);
    checkOutput("drain_end_valid", 32'(out_valid), 32'd0);
    checkOutput("drain_end_ready", 32'(in_ready),  32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
